// File: rtl/mips_boot_loader.sv
// Boot loader for MIPS_CORE. It takes a length-prefixed, XOR-checksummed byte
// stream, writes it into instruction memory as big-endian 32-bit words, and
// keeps the core in reset until the whole image has arrived and verified.
module mips_boot_loader #(
    parameter int IMEM_DEPTH = 64,
    parameter int ADDR_W     = 6
) (
    input  logic              GlobalClock,
    input  logic              GlobalReset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              load_done,
    output logic              load_error
);

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_ERR
    } state_t;

    localparam logic [15:0] MAX_LEN = 16'(IMEM_DEPTH);

    state_t            state;
    logic [7:0]        lenHi;
    logic [ADDR_W:0]   lenWords;   // validated word count, 1..IMEM_DEPTH
    logic [ADDR_W-1:0] wordIdx;
    logic [1:0]        byteCnt;
    logic [23:0]       asmWord;    // first three bytes of the word in flight
    logic [7:0]        runXor;

    logic              accept;
    logic [15:0]       lenFull;
    logic [7:0]        nextXor;
    logic              lastWord;

    // Handshake and helper terms derived from the current byte
    always_comb begin
        accept   = rx_valid && rx_ready;
        lenFull  = {lenHi, rx_data};
        nextXor  = runXor ^ rx_data;
        lastWord = (({1'b0, wordIdx} + (ADDR_W+1)'(1)) == lenWords);
    end

    // Protocol FSM with registered outputs; imem_we is a single-cycle strobe
    always_ff @(posedge GlobalClock or posedge GlobalReset) begin
        if (GlobalReset) begin
            state      <= S_LEN_HI;
            lenHi      <= '0;
            lenWords   <= '0;
            wordIdx    <= '0;
            byteCnt    <= '0;
            asmWord    <= '0;
            runXor     <= '0;
            rx_ready   <= 1'b1;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_reset <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (accept) begin
                runXor <= nextXor;
                case (state)
                    S_LEN_HI: begin
                        lenHi <= rx_data;
                        state <= S_LEN_LO;
                    end
                    S_LEN_LO: begin
                        if (lenFull == 16'd0 || lenFull > MAX_LEN) begin
                            state      <= S_ERR;
                            rx_ready   <= 1'b0;
                            load_error <= 1'b1;
                        end else begin
                            // Range already checked, so the low bits hold N exactly
                            lenWords <= lenFull[ADDR_W:0];
                            state    <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        byteCnt <= byteCnt + 2'd1;
                        asmWord <= {asmWord[15:0], rx_data};
                        if (byteCnt == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= wordIdx;
                            imem_wdata <= {asmWord, rx_data};
                            wordIdx    <= wordIdx + 1'b1;
                            if (lastWord) state <= S_CSUM;
                        end
                    end
                    S_CSUM: begin
                        rx_ready <= 1'b0;
                        if (nextXor == 8'h00) begin
                            state      <= S_RUN;
                            core_reset <= 1'b0;
                            load_done  <= 1'b1;
                        end else begin
                            state      <= S_ERR;
                            load_error <= 1'b1;
                        end
                    end
                    default: ;  // S_RUN / S_ERR: rx_ready is low, nothing accepted
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mips_boot_loader.sv
// Directed bench for mips_boot_loader: per-cycle vector table for the
// back-to-back cases, plus hand-written gapped and reset-mid-load sequences.
module tb_mips_boot_loader;

    localparam int ADDR_W = 6;

    logic              GlobalClock = 1'b0;
    logic              GlobalReset;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_reset;
    logic              load_done;
    logic              load_error;

    mips_boot_loader #(.IMEM_DEPTH(64), .ADDR_W(ADDR_W)) dut (
        .GlobalClock(GlobalClock),
        .GlobalReset(GlobalReset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 GlobalClock = ~GlobalClock;

    typedef struct {
        bit        rst;
        bit        vld;
        bit [7:0]  data;
        bit        we;
        bit [5:0]  addr;
        bit [31:0] wdata;
        bit        cr;
        bit        done;
        bit        err;
        bit        rdy;
    } vec_t;

    vec_t vecs[$];
    int   passCnt = 0;
    int   totalCnt = 0;

    // Writes observed mid-cycle (imem_we is high for one whole period)
    logic [5:0]  wrAddr[$];
    logic [31:0] wrData[$];
    always @(negedge GlobalClock) begin
        if (imem_we === 1'b1) begin
            wrAddr.push_back(imem_addr);
            wrData.push_back(imem_wdata);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic addVec(input bit rst, input bit vld, input bit [7:0] data,
                          input bit we, input bit [5:0] addr, input bit [31:0] wdata,
                          input bit cr, input bit done, input bit err, input bit rdy);
        vec_t v;
        v.rst = rst; v.vld = vld; v.data = data; v.we = we; v.addr = addr;
        v.wdata = wdata; v.cr = cr; v.done = done; v.err = err; v.rdy = rdy;
        vecs.push_back(v);
    endtask

    // Byte with no visible effect during loading
    task automatic addIdle(input bit [7:0] b);
        addVec(0, 1, b, 0, 0, 0, 1, 0, 0, 1);
    endtask

    task automatic addReset();
        addVec(1, 0, 8'h00, 0, 0, 0, 1, 0, 0, 1);
    endtask

    // Normal two-word image body up to (not including) the checksum byte
    task automatic addNormalBody();
        addIdle(8'h00); addIdle(8'h02);
        addIdle(8'h20); addIdle(8'h08); addIdle(8'h00);
        addVec(0, 1, 8'h05, 1, 6'd0, 32'h20080005, 1, 0, 0, 1);
        addIdle(8'h20); addIdle(8'h09); addIdle(8'h00);
        addVec(0, 1, 8'h0A, 1, 6'd1, 32'h2009000A, 1, 0, 0, 1);
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap);
        for (int g = 0; g < gap; g++) begin
            @(negedge GlobalClock);
            rx_valid = 1'b0;
            rx_data  = 8'hEE;
        end
        @(negedge GlobalClock);
        rx_valid = 1'b1;
        rx_data  = b;
    endtask

    task automatic idleCycles(input int n);
        for (int g = 0; g < n; g++) begin
            @(negedge GlobalClock);
            rx_valid = 1'b0;
        end
    endtask

    task automatic checkNormalWrites(input string tag);
        check({tag, " write count"}, wrAddr.size(), 2);
        if (wrAddr.size() == 2) begin
            check({tag, " addr0"}, wrAddr[0], 0);
            check({tag, " data0"}, wrData[0], 32'h20080005);
            check({tag, " addr1"}, wrAddr[1], 1);
            check({tag, " data1"}, wrData[1], 32'h2009000A);
        end
        check({tag, " load_done"}, load_done, 1);
        check({tag, " load_error"}, load_error, 0);
        check({tag, " core_reset"}, core_reset, 0);
        check({tag, " rx_ready"}, rx_ready, 0);
    endtask

    logic [7:0] normal[11];

    initial begin
        normal = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                   8'h20, 8'h09, 8'h00, 8'h0A, 8'h0C};

        // Normal load, back-to-back; trailing byte in S_RUN is ignored
        addReset();
        addNormalBody();
        addVec(0, 1, 8'h0C, 0, 0, 0, 0, 1, 0, 0);
        addVec(0, 1, 8'hFF, 0, 0, 0, 0, 1, 0, 0);
        // Checksum mismatch: both writes happen, then error
        addReset();
        addNormalBody();
        addVec(0, 1, 8'h0D, 0, 0, 0, 1, 0, 1, 0);
        addVec(0, 1, 8'h0C, 0, 0, 0, 1, 0, 1, 0);
        // Zero length
        addReset();
        addIdle(8'h00);
        addVec(0, 1, 8'h00, 0, 0, 0, 1, 0, 1, 0);
        addVec(0, 1, 8'h00, 0, 0, 0, 1, 0, 1, 0);
        // Oversize length 65
        addReset();
        addIdle(8'h00);
        addVec(0, 1, 8'h41, 0, 0, 0, 1, 0, 1, 0);
        // Oversize via high byte (N=256)
        addReset();
        addIdle(8'h01);
        addVec(0, 1, 8'h00, 0, 0, 0, 1, 0, 1, 0);
        // Single-word image with a valid drop mid-word; CSUM = 01
        addReset();
        addIdle(8'h00); addIdle(8'h01);
        addIdle(8'hAA);
        addVec(0, 0, 8'h55, 0, 0, 0, 1, 0, 0, 1);
        addIdle(8'hBB); addIdle(8'hCC);
        addVec(0, 1, 8'hDD, 1, 6'd0, 32'hAABBCCDD, 1, 0, 0, 1);
        addVec(0, 0, 8'h01, 0, 0, 0, 1, 0, 0, 1);
        addVec(0, 1, 8'h01, 0, 0, 0, 0, 1, 0, 0);

        GlobalReset = 1'b1;
        rx_valid    = 1'b0;
        rx_data     = 8'h00;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge GlobalClock);
            GlobalReset = vecs[i].rst;
            rx_valid    = vecs[i].vld;
            rx_data     = vecs[i].data;
            @(posedge GlobalClock);
            #1;
            check($sformatf("v%0d imem_we", i), imem_we, vecs[i].we);
            if (vecs[i].we) begin
                check($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].addr);
                check($sformatf("v%0d imem_wdata", i), imem_wdata, vecs[i].wdata);
            end
            if (vecs[i].rst) begin
                check($sformatf("v%0d reset addr", i), imem_addr, 0);
                check($sformatf("v%0d reset wdata", i), imem_wdata, 0);
            end
            check($sformatf("v%0d core_reset", i), core_reset, vecs[i].cr);
            check($sformatf("v%0d load_done", i), load_done, vecs[i].done);
            check($sformatf("v%0d load_error", i), load_error, vecs[i].err);
            check($sformatf("v%0d rx_ready", i), rx_ready, vecs[i].rdy);
        end

        // Gapped stream: 1-3 idle cycles before each byte after the first
        @(negedge GlobalClock);
        GlobalReset = 1'b1;
        rx_valid    = 1'b0;
        @(negedge GlobalClock);
        GlobalReset = 1'b0;
        wrAddr.delete();
        wrData.delete();
        for (int i = 0; i < 11; i++) begin
            sendByte(normal[i], (i == 0) ? 0 : int'($urandom_range(3, 1)));
            if (i == 10) begin
                @(posedge GlobalClock);
                #1;
                check("gap done timing", load_done, 1);
            end
        end
        idleCycles(3);
        checkNormalWrites("gapped");

        // Reset mid-load after a partial word, then a full clean load
        @(negedge GlobalClock);
        GlobalReset = 1'b1;
        rx_valid    = 1'b0;
        @(negedge GlobalClock);
        GlobalReset = 1'b0;
        wrAddr.delete();
        wrData.delete();
        for (int i = 0; i < 5; i++) sendByte(normal[i], 0);
        @(negedge GlobalClock);
        rx_valid    = 1'b0;
        GlobalReset = 1'b1;
        #1;
        check("midrst rx_ready", rx_ready, 1);
        check("midrst core_reset", core_reset, 1);
        check("midrst imem_we", imem_we, 0);
        @(negedge GlobalClock);
        GlobalReset = 1'b0;
        #1;
        check("midrst rel rx_ready", rx_ready, 1);
        check("midrst rel core_reset", core_reset, 1);
        check("midrst partial writes", wrAddr.size(), 0);
        for (int i = 0; i < 11; i++) sendByte(normal[i], 0);
        idleCycles(3);
        checkNormalWrites("reload");

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
